conv_out_writer: RTL and testbench
==================================

// Module: conv_out_writer
// PURPOSE
//  Sink for the 3x3 conv engine output stream (out_valid/out_pixel). For one frame it adds a
//  bias, applies an arithmetic right shift, optional ReLU and signed saturation to OUT_W bits.
//  It then writes each result to the next linear address of an output frame buffer.
//  Accepts one pixel per cycle with no backpressure, since the conv engine cannot stall.
// PARAMETERS
//  ACC_W   24  input accumulator width (signed)
//  OUT_W   8   output pixel width (signed)
//  ADDR_W  20  frame-buffer address width
// PORTS
//  clk         in   1       clock
//  rst         in   1       synchronous, active-high reset
//  start       in   1       1-cycle pulse; latches cfg and arms a frame (honoured only in IDLE)
//  img_width   in   16      input image width W (conv output width = W-2)
//  img_height  in   16      input image height H (conv output height = H-2)
//  base_addr   in   ADDR_W  address of first output pixel
//  bias        in   ACC_W   signed bias added before the shift
//  shift       in   5       arithmetic right-shift amount
//  relu_en     in   1       1 = clamp negative results to 0
//  in_valid    in   1       conv output strobe
//  in_pixel    in   ACC_W   signed conv output
//  wr_en       out  1       frame-buffer write strobe
//  wr_addr     out  ADDR_W  write address
//  wr_data     out  OUT_W   signed write data
//  busy        out  1       state != IDLE
//  frame_done  out  1       1-cycle pulse when the frame is complete
//  sat_count   out  16      count of clipped results; saturates at 0xFFFF
//  err_overrun out  1       sticky; set when in_valid is dropped
// BEHAVIOUR
//  - Reset: state IDLE, pipeline valids 0, counters 0. Every output is 0.
//  - Reset mid-frame aborts the frame immediately. No wr_en is issued after rst.
//  - FSM states IDLE, RUN, FLUSH, DONE:
//    - IDLE --start--> RUN. start latches all cfg inputs, sets total=(W-2)*(H-2),
//      clears sat_count, err_overrun and the accept count, and loads the address counter with base_addr.
//    - If W<3 or H<3 at start, IDLE -> DONE directly, with no writes.
//    - RUN -> FLUSH in the cycle the total-th pixel is accepted.
//    - FLUSH waits until the pipeline is empty, then goes to DONE.
//    - DONE lasts one cycle with frame_done=1, then returns to IDLE.
//  - start outside IDLE is ignored.
//  - in_valid is accepted only in RUN. A pixel in the same cycle as start is not accepted.
//  - Any in_valid in IDLE, FLUSH or DONE is dropped and sets err_overrun.
//  - Pipeline: in_valid in cycle t produces wr_en=1 in cycle t+2. Full throughput is one pixel per cycle.
//    - Stage 1: sum = in_pixel + bias, sign-extended to ACC_W+1 bits, with no wrap.
//    - Stage 2: v = sum >>> shift (floor).
//    - If relu_en and v<0, result is 0; this does not count as saturation.
//    - Otherwise, if v > 2^(OUT_W-1)-1 or v < -2^(OUT_W-1), clip to that bound and increment sat_count.
//  - wr_addr starts at base_addr and increments by 1 per write (row-major).
//    The address wraps modulo 2^ADDR_W.
//  - wr_data and wr_addr hold their last value when wr_en=0.
//  - frame_done is asserted in the cycle after the last wr_en.
// TESTING
//  - W=5, H=5, bias=0, shift=0, relu=0, base=0x100; in_pixel 0..8 back-to-back
//    -> 9 writes, addr 0x100..0x108, data 0..8; frame_done one cycle after the last write.
//  - Saturation: in_pixel 1000 and -1000 (shift=0)
//    -> wr_data 127 and -128; sat_count=2.
//  - Bias, shift and ReLU:
//    - in_pixel=515, bias=5, shift=2 -> 130 -> 127, sat_count+1.
//    - in_pixel=-300 with relu_en=1 -> 0, sat_count unchanged.
//    - in_pixel=-7, shift=1, relu=0 -> -4.
//  - Overrun: a 10th pixel after a 9-pixel frame -> no wr_en and err_overrun=1.
//    The next start clears err_overrun.
//  - Reset mid-frame after 4 of 9 pixels: rst -> no further wr_en, busy=0.
//    A new start then writes the full frame from base_addr.
//  - Degenerate W=2: start -> frame_done 1 cycle later, no writes, busy high for exactly that 1 cycle.

Source files
------------

// File: rtl/conv_out_writer.sv
// Frame sink for the 3x3 conv engine: bias add, arithmetic shift, optional ReLU,
// signed saturation, then linear writes into the output frame buffer.
module conv_out_writer #(
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 8,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       img_width,
  input  logic [15:0]       img_height,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ACC_W-1:0]  bias,
  input  logic [4:0]        shift,
  input  logic              relu_en,
  input  logic              in_valid,
  input  logic [ACC_W-1:0]  in_pixel,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [OUT_W-1:0]  wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       sat_count,
  output logic              err_overrun
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam int STAGES = 1;
  localparam logic signed [ACC_W:0] MAX_V = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;

  typedef struct packed {
    logic [ACC_W-1:0] bias;
    logic [4:0]       shift;
    logic             relu;
  } cfg_t;

  logic [1:0]            state;
  cfg_t                  cfg;
  logic [31:0]           total, acc_cnt;
  logic [ADDR_W-1:0]     addr_cnt;
  logic [STAGES:0]       vld_pipe;
  logic signed [ACC_W:0] sum_q, shifted;
  logic [OUT_W-1:0]      res;
  logic                  clip, accept, degenerate;

  assign accept     = (state == S_RUN) && in_valid;
  assign degenerate = (img_width < 16'd3) || (img_height < 16'd3);
  assign shifted    = sum_q >>> cfg.shift;

  // ReLU takes priority so a zeroed negative never counts as a clip.
  always_comb begin
    res  = shifted[OUT_W-1:0];
    clip = 1'b0;
    if (cfg.relu && shifted[ACC_W]) begin
      res = '0;
    end else if (shifted > MAX_V) begin
      res  = MAX_V[OUT_W-1:0];
      clip = 1'b1;
    end else if (shifted < MIN_V) begin
      res  = MIN_V[OUT_W-1:0];
      clip = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cfg         <= '0;
      total       <= '0;
      acc_cnt     <= '0;
      addr_cnt    <= '0;
      vld_pipe    <= '0;
      sum_q       <= '0;
      wr_addr     <= '0;
      wr_data     <= '0;
      sat_count   <= '0;
      err_overrun <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], accept};
      if (accept) begin
        sum_q   <= $signed({in_pixel[ACC_W-1], in_pixel}) + $signed({cfg.bias[ACC_W-1], cfg.bias});
        acc_cnt <= acc_cnt + 32'd1;
      end
      if (vld_pipe[0]) begin
        wr_addr  <= addr_cnt;
        wr_data  <= res;
        addr_cnt <= addr_cnt + 1'b1;
        if (clip && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
      end
      case (state)
        S_IDLE: if (start) begin
          cfg.bias    <= bias;
          cfg.shift   <= shift;
          cfg.relu    <= relu_en;
          total       <= 32'(img_width - 16'd2) * 32'(img_height - 16'd2);
          acc_cnt     <= '0;
          addr_cnt    <= base_addr;
          sat_count   <= '0;
          err_overrun <= 1'b0;
          state       <= degenerate ? S_DONE : S_RUN;
        end
        S_RUN:   if (accept && (acc_cnt + 32'd1 == total)) state <= S_FLUSH;
        // Stage 2 is the write itself, so only stage 1 has to drain.
        S_FLUSH: if (!vld_pipe[0]) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
      if (in_valid && state != S_RUN) err_overrun <= 1'b1;
    end
  end

  assign wr_en      = vld_pipe[STAGES];
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);

endmodule

// File: tb/tb_conv_out_writer.sv
// Randomised and directed checks of conv_out_writer against an arithmetic model
// of the bias/shift/ReLU/saturate rules and the linear write addressing.
module tb_conv_out_writer;
  logic        clk = 1'b0;
  logic        rst, start, relu_en, in_valid;
  logic [15:0] img_width, img_height;
  logic [19:0] base_addr;
  logic [23:0] bias, in_pixel;
  logic [4:0]  shift;
  logic        wr_en, busy, frame_done, err_overrun;
  logic [19:0] wr_addr;
  logic [7:0]  wr_data;
  logic [15:0] sat_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int first_px_cyc;
  int stim[$];
  logic [19:0]       wr_a[$];
  logic signed [7:0] wr_d[$];
  int                wr_c[$];
  int                done_c[$];

  conv_out_writer #(.ACC_W(24), .OUT_W(8), .ADDR_W(20)) dut (
    .clk(clk), .rst(rst), .start(start), .img_width(img_width), .img_height(img_height),
    .base_addr(base_addr), .bias(bias), .shift(shift), .relu_en(relu_en),
    .in_valid(in_valid), .in_pixel(in_pixel), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .frame_done(frame_done), .sat_count(sat_count),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_a.push_back(wr_addr);
      wr_d.push_back(wr_data);
      wr_c.push_back(cyc);
    end
    if (frame_done === 1'b1) done_c.push_back(cyc);
  end

  function automatic int model_px(input int p, input int b, input int s, input bit r, output bit clipped);
    longint v;
    v = (longint'(p) + longint'(b)) >>> s;
    clipped = 1'b0;
    if (r && v < 0) return 0;
    if (v > 127)  begin clipped = 1'b1; return 127;  end
    if (v < -128) begin clipped = 1'b1; return -128; end
    return int'(v);
  endfunction

  task automatic drive_frame(input int w, input int h, input logic [19:0] base, input int b,
                             input int s, input bit r, input bit gaps, input bit junk,
                             input int n_feed, input bit wait_done, output bit done_seen);
    wr_a.delete(); wr_d.delete(); wr_c.delete(); done_c.delete();
    @(negedge clk);
    img_width = 16'(w); img_height = 16'(h); base_addr = base;
    bias = 24'(b); shift = 5'(s); relu_en = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n_feed; i++) begin
      while (gaps && $urandom_range(0, 2) == 0) @(negedge clk);
      in_valid = 1'b1;
      in_pixel = 24'(stim[i]);
      if (i == 0) first_px_cyc = cyc;
      if (junk && i < n_feed - 1 && $urandom_range(0, 3) == 0) begin
        start = 1'b1; img_width = 16'($urandom); img_height = 16'($urandom);
        base_addr = 20'($urandom); bias = 24'($urandom); shift = 5'($urandom);
        relu_en = 1'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
    end
    done_seen = 1'b0;
    if (wait_done) begin
      for (int k = 0; k < 20 && !done_seen; k++) begin
        if (frame_done === 1'b1) done_seen = 1'b1;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_pixel = '0; img_width = '0; img_height = '0;
    base_addr = '0; bias = '0; shift = '0; relu_en = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({wr_en, wr_addr, wr_data, busy, frame_done, sat_count, err_overrun} !== 48'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b addr=%h data=%h busy=%b done=%b sat=%h err=%b, want all 0",
               wr_en, wr_addr, wr_data, busy, frame_done, sat_count, err_overrun);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({wr_en, busy, frame_done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_release: got en/busy/done=%b want 000", {wr_en, busy, frame_done});
    end
  endtask

  task automatic test_basic();
    bit done;
    stim.delete();
    for (int i = 0; i < 9; i++) stim.push_back(i);
    drive_frame(5, 5, 20'h100, 0, 0, 1'b0, 1'b0, 1'b0, 9, 1'b1, done);
    n_checks++;
    if (!done || wr_a.size() != 9) begin
      n_fail++;
      $display("FAIL basic_count: got done=%0d writes=%0d want 1 / 9", done, wr_a.size());
    end
    for (int i = 0; i < wr_a.size(); i++) begin
      n_checks++;
      if (wr_a[i] !== 20'(32'h100 + i) || wr_d[i] !== 8'(i) || wr_c[i] != wr_c[0] + i) begin
        n_fail++;
        $display("FAIL basic_write[%0d]: got addr=%h data=%0d cyc=%0d want addr=%h data=%0d cyc=%0d",
                 i, wr_a[i], wr_d[i], wr_c[i], 32'h100 + i, i, wr_c[0] + i);
      end
    end
    if (wr_c.size() > 0) begin
      n_checks++;
      if (wr_c[0] != first_px_cyc + 2) begin
        n_fail++;
        $display("FAIL basic_latency: first write cyc=%0d want %0d", wr_c[0], first_px_cyc + 2);
      end
      n_checks++;
      if (done_c.size() != 1 || done_c[0] != wr_c[wr_c.size()-1] + 1) begin
        n_fail++;
        $display("FAIL basic_done_timing: got %0d pulses first at %0d, want 1 at %0d",
                 done_c.size(), (done_c.size() > 0) ? done_c[0] : -1, wr_c[wr_c.size()-1] + 1);
      end
    end
    n_checks++;
    if ({busy, err_overrun, sat_count, wr_addr, wr_data} !== {1'b0, 1'b0, 16'd0, 20'h108, 8'd8}) begin
      n_fail++;
      $display("FAIL basic_idle_hold: got busy=%b err=%b sat=%0d addr=%h data=%0d want 0 0 0 108 8",
               busy, err_overrun, sat_count, wr_addr, wr_data);
    end
  endtask

  task automatic test_saturation();
    bit done;
    stim.delete(); stim.push_back(1000); stim.push_back(-1000);
    drive_frame(3, 4, 20'h0, 0, 0, 1'b0, 1'b0, 1'b0, 2, 1'b1, done);
    n_checks++;
    if (!done || wr_a.size() != 2 || wr_d[0] !== 8'sd127 || wr_d[1] !== -8'sd128 || sat_count !== 16'd2) begin
      n_fail++;
      $display("FAIL saturation: got done=%0d n=%0d d0=%0d d1=%0d sat=%0d want 1 2 127 -128 2", done,
               wr_a.size(), (wr_d.size() > 0) ? wr_d[0] : 8'sd0, (wr_d.size() > 1) ? wr_d[1] : 8'sd0, sat_count);
    end
  endtask

  task automatic test_bias_shift_relu();
    bit done;
    int w, b, s, n, sat_exp;
    bit r;
    logic signed [7:0] e0, e1;
    for (int f = 0; f < 3; f++) begin
      stim.delete();
      case (f)
        0: begin w = 3; b = 5; s = 2; r = 0; stim.push_back(515); e0 = 8'sd127; e1 = 8'sd0; n = 1; sat_exp = 1; end
        1: begin w = 4; b = 0; s = 0; r = 1; stim.push_back(1000); stim.push_back(-300);
                 e0 = 8'sd127; e1 = 8'sd0; n = 2; sat_exp = 1; end
        default: begin w = 3; b = 0; s = 1; r = 0; stim.push_back(-7); e0 = -8'sd4; e1 = 8'sd0; n = 1; sat_exp = 0; end
      endcase
      drive_frame(w, 3, 20'h40, b, s, r, 1'b0, 1'b0, n, 1'b1, done);
      n_checks++;
      if (!done || wr_a.size() != n || wr_d[0] !== e0 || (n == 2 && wr_d[1] !== e1) || sat_count !== 16'(sat_exp)) begin
        n_fail++;
        $display("FAIL bias_shift_relu[%0d]: got n=%0d d0=%0d sat=%0d want n=%0d d0=%0d d1=%0d sat=%0d",
                 f, wr_a.size(), (wr_d.size() > 0) ? wr_d[0] : 8'sd0, sat_count, n, e0, e1, sat_exp);
      end
    end
  endtask

  task automatic test_overrun();
    bit done, c;
    stim.delete();
    for (int i = 0; i < 9; i++) stim.push_back(int'($urandom_range(0, 200)) - 100);
    drive_frame(5, 5, 20'h2000, 0, 0, 1'b0, 1'b0, 1'b0, 9, 1'b0, done);
    in_valid = 1'b1; in_pixel = 24'd55;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (frame_done === 1'b1) done = 1'b1;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (!done || wr_a.size() != 9 || err_overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun: got done=%0d writes=%0d err=%b want 1 9 1", done, wr_a.size(), err_overrun);
    end
    for (int i = 0; i < wr_d.size(); i++) begin
      n_checks++;
      if (wr_d[i] !== 8'(model_px(stim[i], 0, 0, 1'b0, c))) begin
        n_fail++;
        $display("FAIL overrun_data[%0d]: got %0d want %0d", i, wr_d[i], model_px(stim[i], 0, 0, 1'b0, c));
      end
    end
    stim.delete(); stim.push_back(3);
    drive_frame(3, 3, 20'h0, 0, 0, 1'b0, 1'b0, 1'b0, 1, 1'b1, done);
    n_checks++;
    if (!done || err_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: got done=%0d err=%b want 1 0", done, err_overrun);
    end
  endtask

  task automatic test_reset_mid();
    bit done, c, bad;
    stim.delete();
    for (int i = 0; i < 9; i++) stim.push_back(int'($urandom_range(0, 400)) - 200);
    drive_frame(5, 5, 20'h300, 3, 1, 1'b0, 1'b0, 1'b0, 4, 1'b0, done);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (wr_en !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: got activity after rst (en=%b busy=%b) want none", wr_en, busy);
    end
    drive_frame(5, 5, 20'h300, 3, 1, 1'b0, 1'b0, 1'b0, 9, 1'b1, done);
    n_checks++;
    if (!done || wr_a.size() != 9) begin
      n_fail++;
      $display("FAIL reset_mid_refill: got done=%0d writes=%0d want 1 9", done, wr_a.size());
    end
    for (int i = 0; i < wr_a.size(); i++) begin
      n_checks++;
      if (wr_a[i] !== 20'(32'h300 + i) || wr_d[i] !== 8'(model_px(stim[i], 3, 1, 1'b0, c))) begin
        n_fail++;
        $display("FAIL reset_mid_write[%0d]: got addr=%h data=%0d want addr=%h data=%0d", i, wr_a[i], wr_d[i],
                 32'h300 + i, model_px(stim[i], 3, 1, 1'b0, c));
      end
    end
  endtask

  task automatic test_degenerate();
    for (int k = 0; k < 2; k++) begin
      wr_a.delete(); wr_d.delete(); wr_c.delete(); done_c.delete();
      @(negedge clk);
      img_width = (k == 0) ? 16'd2 : 16'd9; img_height = (k == 0) ? 16'd7 : 16'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if ({frame_done, busy} !== 2'b11) begin
        n_fail++;
        $display("FAIL degenerate_done[%0d]: got done/busy=%b want 11", k, {frame_done, busy});
      end
      @(negedge clk);
      n_checks++;
      if ({frame_done, busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL degenerate_idle[%0d]: got done/busy=%b want 00", k, {frame_done, busy});
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (wr_a.size() != 0) begin
        n_fail++;
        $display("FAIL degenerate_writes[%0d]: got %0d writes want 0", k, wr_a.size());
      end
    end
  endtask

  task automatic test_random();
    bit done, c, r;
    int w, h, b, s, n, sat_exp;
    logic [19:0] base;
    for (int f = 0; f < 5; f++) begin
      w = int'($urandom_range(3, 6)); h = int'($urandom_range(3, 6)); n = (w - 2) * (h - 2);
      b = int'($urandom_range(0, 4000)) - 2000; s = int'($urandom_range(0, 12)); r = 1'($urandom);
      base = (f == 0) ? 20'hFFFFE : 20'($urandom);
      stim.delete();
      for (int i = 0; i < n; i++)
        stim.push_back($urandom_range(0, 1) ? int'($urandom_range(0, 600)) - 300
                                             : int'($urandom_range(0, 24'hFFFFFF)) - (1 << 23));
      drive_frame(w, h, base, b, s, r, 1'b1, 1'b1, n, 1'b1, done);
      sat_exp = 0;
      n_checks++;
      if (!done || wr_a.size() != n || done_c.size() != 1) begin
        n_fail++;
        $display("FAIL random_count[%0d]: got done=%0d writes=%0d pulses=%0d want 1 %0d 1", f, done,
                 wr_a.size(), done_c.size(), n);
      end
      for (int i = 0; i < wr_a.size() && i < n; i++) begin
        n_checks++;
        if (wr_a[i] !== 20'(base + 20'(i)) || wr_d[i] !== 8'(model_px(stim[i], b, s, r, c))) begin
          n_fail++;
          $display("FAIL random_write[%0d.%0d]: got addr=%h data=%0d want addr=%h data=%0d", f, i, wr_a[i],
                   wr_d[i], 20'(base + 20'(i)), model_px(stim[i], b, s, r, c));
        end
      end
      for (int i = 0; i < n; i++) begin
        void'(model_px(stim[i], b, s, r, c));
        if (c) sat_exp++;
      end
      n_checks++;
      if (sat_count !== 16'(sat_exp) || err_overrun !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL random_status[%0d]: got sat=%0d err=%b busy=%b want sat=%0d err=0 busy=0", f,
                 sat_count, err_overrun, busy, sat_exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_bias_shift_relu();
    test_overrun();
    test_reset_mid();
    test_degenerate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end
endmodule
